// File: rtl/mem_access_ctrl_if.sv
// Datapath and memory-side signal bundle for mem_access_ctrl.
// slave is the controller's view; master is the surrounding environment.
interface mem_access_ctrl_if;
  logic [15:0] eabOut;
  logic [15:0] wdata;
  logic        req;
  logic        we;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] mdr;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memEn;
  logic        memWe;
  logic        memRdy;
  logic [15:0] memRdata;

  modport slave (
    input  eabOut, wdata, req, we,
    input  memRdy, memRdata,
    output busy, done, err, mdr,
    output memAddr, memWdata, memEn, memWe
  );

  modport master (
    output eabOut, wdata, req, we,
    output memRdy, memRdata,
    input  busy, done, err, mdr,
    input  memAddr, memWdata, memEn, memWe
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory access controller with ready handshake.
// Define MEM_TIMEOUT_EN to enable the ACCESS wait timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] mar;
  logic [15:0] mdr_q;
  logic        we_q;
  logic        accept;
  logic        hit;
  logic        expire;

  assign accept = (state == IDLE) && bus.req;
  assign hit    = (state == ACCESS) && bus.memRdy;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  // Count reaches TIMEOUT on the edge that ends the last allowed cycle
  assign expire = (state == ACCESS) && !bus.memRdy &&
                  (cnt >= 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (state == ACCESS && !bus.memRdy) begin
      if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      if (expire)
        err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign expire  = 1'b0;
  // TIMEOUT is at least 1, so this ties err low
  assign bus.err = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.req) state_n = ACCESS;
      ACCESS:  if (hit || expire) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar   <= '0;
      mdr_q <= '0;
      we_q  <= 1'b0;
    end else if (accept) begin
      mar  <= bus.eabOut;
      we_q <= bus.we;
      if (bus.we)
        mdr_q <= bus.wdata;
    end else if (hit && !we_q) begin
      mdr_q <= bus.memRdata;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.memEn    = (state == ACCESS);
  assign bus.memWe    = (state == ACCESS) && we_q;
  assign bus.memAddr  = mar;
  assign bus.memWdata = mdr_q;
  assign bus.mdr      = mdr_q;

endmodule
